// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared constants and types for the iterative restoring divider (div16).
//   DIV_N        default divisor/remainder width (dividend/quotient are 2N)
//   DIV_CNT_W    step-counter width for the default width
//   DIV_LATENCY  clock edges from the start edge to done for a nonzero divisor
//   state_e      controller state encoding
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int unsigned DIV_N       = 16;
    localparam int unsigned DIV_CNT_W   = $clog2(2 * DIV_N);
    localparam int unsigned DIV_LATENCY = 2 * DIV_N;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : div_pkg

// File: rtl/div16_if.sv
// ---------------------------------------------------------------------------
// div16_if
// Start/done handshake plus operand and result buses of the divider.
//   start        1   one-cycle pulse, registers operands and begins an operation
//   dividend     2N  numerator, sampled on the start edge only
//   divisor      N   denominator, sampled on the start edge only
//   quotient     2N  result, valid while done=1
//   remainder    N   result, valid while done=1
//   div_by_zero  1   set with done when the registered divisor was 0
//   done         1   1 = idle / results valid, 0 = busy
// Modports: master drives the request side, slave is the divider itself.
// ---------------------------------------------------------------------------
interface div16_if
    import div_pkg::*;
#(
    parameter int unsigned N = DIV_N
);

    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;
    logic             done;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, div_by_zero, done
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, div_by_zero, done
    );

endinterface : div16_if

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One restoring shift-subtract step, purely combinational.
//   rem_i       N   partial remainder before the step (always < dsr_i)
//   msb_i       1   next dividend bit shifted in
//   dsr_i       N   divisor
//   rem_next_o  N   partial remainder after the step
//   qbit_o      1   quotient bit produced by the step
// ---------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int unsigned N = DIV_N
) (
    input  logic [N-1:0] rem_i,
    input  logic         msb_i,
    input  logic [N-1:0] dsr_i,
    output logic [N-1:0] rem_next_o,
    output logic         qbit_o
);

    // Trial value needs N+1 bits: the shifted remainder can reach 2*dsr-1.
    logic [N:0]   trial;
    logic [N-1:0] trial_lo;

    assign trial    = {rem_i, msb_i};
    assign trial_lo = {rem_i[N-2:0], msb_i};
    assign qbit_o   = (trial >= {1'b0, dsr_i});

    // When the subtraction happens the true difference is below dsr_i, so it
    // fits in N bits and modulo-2^N arithmetic on the low bits is exact.
    assign rem_next_o = qbit_o ? (trial_lo - dsr_i) : trial_lo;

endmodule : div_step

// File: rtl/div16.sv
// ---------------------------------------------------------------------------
// div16
// Unsigned iterative divider: 2N-bit dividend / N-bit divisor -> 2N-bit
// quotient and N-bit remainder, one quotient bit per clock (restoring
// algorithm). done rises exactly 2N edges after the start edge, or one edge
// after it when the divisor is zero.
//   clk     1  clock, rising edge
//   resetb  1  synchronous active-low reset
//   bus     div16_if.slave  start/done handshake, operands and results
// ---------------------------------------------------------------------------
module div16
    import div_pkg::*;
#(
    parameter int unsigned N = DIV_N
) (
    input  logic  clk,
    input  logic  resetb,
    div16_if.slave bus
);

    localparam int unsigned          CNT_W    = $clog2(2 * N);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(2 * N - 1);

    state_e           state_q;
    logic [2*N-1:0]   dvd_q;        // dividend, shifted left one bit per step
    logic [N-1:0]     dsr_q;
    logic [N-1:0]     rem_q;        // partial remainder; the step's extra bit is transient
    logic [2*N-2:0]   quo_q;        // quotient bits so far; the last bit goes straight out
    logic [CNT_W-1:0] cnt_q;
    logic [2*N-1:0]   quotient_q;
    logic [N-1:0]     remainder_q;
    logic             dbz_q;
    logic             done_q;

    logic [N-1:0]     rem_next;
    logic             qbit;

    div_step #(.N(N)) u_step (
        .rem_i      (rem_q),
        .msb_i      (dvd_q[2*N-1]),
        .dsr_i      (dsr_q),
        .rem_next_o (rem_next),
        .qbit_o     (qbit)
    );

    // Results live in their own registers so they only move on completion,
    // start or reset, never while the working registers iterate.
    // NOTE: state is written with <= so every register samples the values from
    // before this edge; blocking = here would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b1;
        end else if (bus.start) begin
            // Start wins in any state, so a start during RUN restarts cleanly.
            state_q     <= RUN;
            dvd_q       <= bus.dividend;
            dsr_q       <= bus.divisor;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else if (state_q == RUN) begin
            if (dsr_q == '0) begin
                quotient_q  <= '1;
                remainder_q <= dvd_q[N-1:0];
                dbz_q       <= 1'b1;
                done_q      <= 1'b1;
                state_q     <= IDLE;
            end else begin
                dvd_q <= dvd_q << 1;
                rem_q <= rem_next;
                quo_q <= {quo_q[2*N-3:0], qbit};
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    quotient_q  <= {quo_q, qbit};
                    remainder_q <= rem_next;
                    done_q      <= 1'b1;
                    state_q     <= IDLE;
                end
            end
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.done        = done_q;

endmodule : div16

// File: tb/tb_div16.sv
// ---------------------------------------------------------------------------
// tb_div16
// Self-checking bench for div16: a table of directed vectors, hand-written
// abort/reset/hold sequences, and random operands against an arithmetic
// reference model.
// ---------------------------------------------------------------------------
module tb_div16;
    import div_pkg::*;

    localparam int unsigned N = DIV_N;

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dsr;
        logic [31:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    logic clk;
    logic resetb;
    int   n_vec;
    int   n_err;

    div16_if #(.N(N)) bus ();

    div16 #(.N(N)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, with the zero-divisor convention.
    function automatic void ref_div(input logic [31:0] dvd, input logic [15:0] dsr,
                                    output logic [31:0] q, output logic [15:0] r,
                                    output logic z, output int lat);
        longint unsigned a, b;
        a = longint'(dvd);
        b = longint'(dsr);
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = dvd[15:0];
            z = 1'b1;
            lat = 1;
        end else begin
            q = 32'(a / b);
            r = 16'(a % b);
            z = 1'b0;
            lat = DIV_LATENCY;
        end
    endfunction

    // Counts edges after the current point until done is seen high (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 3 * DIV_LATENCY) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.done) break;
        end
        if (bus.done !== 1'b1) check("done_timeout", {63'd0, bus.done}, 64'd1);
    endtask

    // Pulses start with the operands, then scrambles the operand inputs so a
    // design that keeps sampling them would produce wrong results.
    task automatic pulse_start(input logic [31:0] dvd, input logic [15:0] dsr);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dsr;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = 16'($urandom);
    endtask

    task automatic run_op(input logic [31:0] dvd, input logic [15:0] dsr, output int lat);
        @(negedge clk);
        pulse_start(dvd, dsr);
        check("busy_after_start", {63'd0, bus.done}, 64'd0);
        wait_done(lat);
    endtask

    task automatic apply(input string tag, input vec_t v);
        int lat;
        run_op(v.dvd, v.dsr, lat);
        check({tag, "_lat"}, 64'(lat), 64'(v.lat));
        check({tag, "_q"},   64'(bus.quotient), 64'(v.q));
        check({tag, "_r"},   64'(bus.remainder), 64'(v.r));
        check({tag, "_dbz"}, {63'd0, bus.div_by_zero}, {63'd0, v.dbz});
    endtask

    vec_t table_v[7];

    initial begin
        logic [31:0] q_m;
        logic [15:0] r_m;
        logic        z_m;
        int          lat_m;
        int          lat;
        vec_t        v;
        logic [31:0] held_q;

        n_vec = 0;
        n_err = 0;

        table_v[0] = '{32'h0000_03E8, 16'h0007, 32'd142,        16'd6,      1'b0, 32};
        table_v[1] = '{32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001,  16'd0,      1'b0, 32};
        table_v[2] = '{32'h0001_0000, 16'h0010, 32'h0000_1000,  16'd0,      1'b0, 32};
        table_v[3] = '{32'd5,         16'd9,    32'd0,          16'd5,      1'b0, 32};
        table_v[4] = '{32'd0,         16'h1234, 32'd0,          16'd0,      1'b0, 32};
        table_v[5] = '{32'h1234_5678, 16'h0000, 32'hFFFF_FFFF,  16'h5678,   1'b1, 1};
        table_v[6] = '{32'hDEAD_BEEF, 16'h0001, 32'hDEAD_BEEF,  16'd0,      1'b0, 32};

        // Reset state.
        resetb       = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", {63'd0, bus.done}, 64'd1);
        check("rst_q",    64'(bus.quotient), 64'd0);
        check("rst_r",    64'(bus.remainder), 64'd0);
        check("rst_dbz",  {63'd0, bus.div_by_zero}, 64'd0);
        @(negedge clk);
        resetb = 1'b1;

        // Directed table.
        foreach (table_v[i]) apply($sformatf("vec%0d", i), table_v[i]);

        // Divide-by-zero result, then a nonzero start must clear the flag.
        v = table_v[5];
        apply("dbz", v);
        @(negedge clk);
        pulse_start(32'd100, 16'd3);
        check("dbz_clear_flag", {63'd0, bus.div_by_zero}, 64'd0);
        check("dbz_clear_q",    64'(bus.quotient), 64'd0);
        wait_done(lat);
        check("dbz_next_q", 64'(bus.quotient), 64'd33);
        check("dbz_next_r", 64'(bus.remainder), 64'd1);

        // Results hold while idle.
        held_q = bus.quotient;
        repeat (7) @(posedge clk);
        #1;
        check("idle_hold_q", 64'(bus.quotient), 64'(held_q));
        check("idle_hold_done", {63'd0, bus.done}, 64'd1);

        // Abort: restart after 10 RUN edges; latency counts from the restart.
        @(negedge clk);
        pulse_start(32'd1000, 16'd7);
        repeat (9) @(posedge clk);
        #1;
        check("abort_busy", {63'd0, bus.done}, 64'd0);
        pulse_start(32'd77, 16'd10);
        wait_done(lat);
        check("abort_lat", 64'(lat), 64'(DIV_LATENCY));
        check("abort_q",   64'(bus.quotient), 64'd7);
        check("abort_r",   64'(bus.remainder), 64'd7);

        // Reset mid-run.
        @(negedge clk);
        pulse_start(32'hCAFE_F00D, 16'h0123);
        repeat (5) @(posedge clk);
        #1;
        resetb = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_done", {63'd0, bus.done}, 64'd1);
        check("midrst_q",    64'(bus.quotient), 64'd0);
        check("midrst_r",    64'(bus.remainder), 64'd0);
        resetb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_stays_idle", {63'd0, bus.done}, 64'd1);

        // Random operands plus divisor=1 and dividend=0 corners.
        for (int k = 0; k < 12; k++) begin
            logic [31:0] a;
            logic [15:0] b;
            a = $urandom;
            b = 16'($urandom);
            if (b == 0) b = 16'd1;
            if (k == 10) b = 16'd1;
            if (k == 11) a = 32'd0;
            ref_div(a, b, q_m, r_m, z_m, lat_m);
            v = '{a, b, q_m, r_m, z_m, lat_m};
            apply($sformatf("rnd%0d", k), v);
            check($sformatf("rnd%0d_inv", k),
                  64'(bus.quotient) * 64'(b) + 64'(bus.remainder), 64'(a));
            check($sformatf("rnd%0d_rlt", k), {63'd0, (bus.remainder < b)}, 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_div16
